// File: rtl/sub_shift_rows.sv
// AES-128 SubBytes + ShiftRows, iterated over SBOX_COUNT S-box lanes per cycle.
// A finished state is held on data_out under a valid/ready handshake until taken.

module sub_shift_rows_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  always_comb begin
    out_o = 8'h00;
    case (in_i)
      8'h00: out_o = 8'h63; 8'h01: out_o = 8'h7c; 8'h02: out_o = 8'h77; 8'h03: out_o = 8'h7b;
      8'h04: out_o = 8'hf2; 8'h05: out_o = 8'h6b; 8'h06: out_o = 8'h6f; 8'h07: out_o = 8'hc5;
      8'h08: out_o = 8'h30; 8'h09: out_o = 8'h01; 8'h0a: out_o = 8'h67; 8'h0b: out_o = 8'h2b;
      8'h0c: out_o = 8'hfe; 8'h0d: out_o = 8'hd7; 8'h0e: out_o = 8'hab; 8'h0f: out_o = 8'h76;
      8'h10: out_o = 8'hca; 8'h11: out_o = 8'h82; 8'h12: out_o = 8'hc9; 8'h13: out_o = 8'h7d;
      8'h14: out_o = 8'hfa; 8'h15: out_o = 8'h59; 8'h16: out_o = 8'h47; 8'h17: out_o = 8'hf0;
      8'h18: out_o = 8'had; 8'h19: out_o = 8'hd4; 8'h1a: out_o = 8'ha2; 8'h1b: out_o = 8'haf;
      8'h1c: out_o = 8'h9c; 8'h1d: out_o = 8'ha4; 8'h1e: out_o = 8'h72; 8'h1f: out_o = 8'hc0;
      8'h20: out_o = 8'hb7; 8'h21: out_o = 8'hfd; 8'h22: out_o = 8'h93; 8'h23: out_o = 8'h26;
      8'h24: out_o = 8'h36; 8'h25: out_o = 8'h3f; 8'h26: out_o = 8'hf7; 8'h27: out_o = 8'hcc;
      8'h28: out_o = 8'h34; 8'h29: out_o = 8'ha5; 8'h2a: out_o = 8'he5; 8'h2b: out_o = 8'hf1;
      8'h2c: out_o = 8'h71; 8'h2d: out_o = 8'hd8; 8'h2e: out_o = 8'h31; 8'h2f: out_o = 8'h15;
      8'h30: out_o = 8'h04; 8'h31: out_o = 8'hc7; 8'h32: out_o = 8'h23; 8'h33: out_o = 8'hc3;
      8'h34: out_o = 8'h18; 8'h35: out_o = 8'h96; 8'h36: out_o = 8'h05; 8'h37: out_o = 8'h9a;
      8'h38: out_o = 8'h07; 8'h39: out_o = 8'h12; 8'h3a: out_o = 8'h80; 8'h3b: out_o = 8'he2;
      8'h3c: out_o = 8'heb; 8'h3d: out_o = 8'h27; 8'h3e: out_o = 8'hb2; 8'h3f: out_o = 8'h75;
      8'h40: out_o = 8'h09; 8'h41: out_o = 8'h83; 8'h42: out_o = 8'h2c; 8'h43: out_o = 8'h1a;
      8'h44: out_o = 8'h1b; 8'h45: out_o = 8'h6e; 8'h46: out_o = 8'h5a; 8'h47: out_o = 8'ha0;
      8'h48: out_o = 8'h52; 8'h49: out_o = 8'h3b; 8'h4a: out_o = 8'hd6; 8'h4b: out_o = 8'hb3;
      8'h4c: out_o = 8'h29; 8'h4d: out_o = 8'he3; 8'h4e: out_o = 8'h2f; 8'h4f: out_o = 8'h84;
      8'h50: out_o = 8'h53; 8'h51: out_o = 8'hd1; 8'h52: out_o = 8'h00; 8'h53: out_o = 8'hed;
      8'h54: out_o = 8'h20; 8'h55: out_o = 8'hfc; 8'h56: out_o = 8'hb1; 8'h57: out_o = 8'h5b;
      8'h58: out_o = 8'h6a; 8'h59: out_o = 8'hcb; 8'h5a: out_o = 8'hbe; 8'h5b: out_o = 8'h39;
      8'h5c: out_o = 8'h4a; 8'h5d: out_o = 8'h4c; 8'h5e: out_o = 8'h58; 8'h5f: out_o = 8'hcf;
      8'h60: out_o = 8'hd0; 8'h61: out_o = 8'hef; 8'h62: out_o = 8'haa; 8'h63: out_o = 8'hfb;
      8'h64: out_o = 8'h43; 8'h65: out_o = 8'h4d; 8'h66: out_o = 8'h33; 8'h67: out_o = 8'h85;
      8'h68: out_o = 8'h45; 8'h69: out_o = 8'hf9; 8'h6a: out_o = 8'h02; 8'h6b: out_o = 8'h7f;
      8'h6c: out_o = 8'h50; 8'h6d: out_o = 8'h3c; 8'h6e: out_o = 8'h9f; 8'h6f: out_o = 8'ha8;
      8'h70: out_o = 8'h51; 8'h71: out_o = 8'ha3; 8'h72: out_o = 8'h40; 8'h73: out_o = 8'h8f;
      8'h74: out_o = 8'h92; 8'h75: out_o = 8'h9d; 8'h76: out_o = 8'h38; 8'h77: out_o = 8'hf5;
      8'h78: out_o = 8'hbc; 8'h79: out_o = 8'hb6; 8'h7a: out_o = 8'hda; 8'h7b: out_o = 8'h21;
      8'h7c: out_o = 8'h10; 8'h7d: out_o = 8'hff; 8'h7e: out_o = 8'hf3; 8'h7f: out_o = 8'hd2;
      8'h80: out_o = 8'hcd; 8'h81: out_o = 8'h0c; 8'h82: out_o = 8'h13; 8'h83: out_o = 8'hec;
      8'h84: out_o = 8'h5f; 8'h85: out_o = 8'h97; 8'h86: out_o = 8'h44; 8'h87: out_o = 8'h17;
      8'h88: out_o = 8'hc4; 8'h89: out_o = 8'ha7; 8'h8a: out_o = 8'h7e; 8'h8b: out_o = 8'h3d;
      8'h8c: out_o = 8'h64; 8'h8d: out_o = 8'h5d; 8'h8e: out_o = 8'h19; 8'h8f: out_o = 8'h73;
      8'h90: out_o = 8'h60; 8'h91: out_o = 8'h81; 8'h92: out_o = 8'h4f; 8'h93: out_o = 8'hdc;
      8'h94: out_o = 8'h22; 8'h95: out_o = 8'h2a; 8'h96: out_o = 8'h90; 8'h97: out_o = 8'h88;
      8'h98: out_o = 8'h46; 8'h99: out_o = 8'hee; 8'h9a: out_o = 8'hb8; 8'h9b: out_o = 8'h14;
      8'h9c: out_o = 8'hde; 8'h9d: out_o = 8'h5e; 8'h9e: out_o = 8'h0b; 8'h9f: out_o = 8'hdb;
      8'ha0: out_o = 8'he0; 8'ha1: out_o = 8'h32; 8'ha2: out_o = 8'h3a; 8'ha3: out_o = 8'h0a;
      8'ha4: out_o = 8'h49; 8'ha5: out_o = 8'h06; 8'ha6: out_o = 8'h24; 8'ha7: out_o = 8'h5c;
      8'ha8: out_o = 8'hc2; 8'ha9: out_o = 8'hd3; 8'haa: out_o = 8'hac; 8'hab: out_o = 8'h62;
      8'hac: out_o = 8'h91; 8'had: out_o = 8'h95; 8'hae: out_o = 8'he4; 8'haf: out_o = 8'h79;
      8'hb0: out_o = 8'he7; 8'hb1: out_o = 8'hc8; 8'hb2: out_o = 8'h37; 8'hb3: out_o = 8'h6d;
      8'hb4: out_o = 8'h8d; 8'hb5: out_o = 8'hd5; 8'hb6: out_o = 8'h4e; 8'hb7: out_o = 8'ha9;
      8'hb8: out_o = 8'h6c; 8'hb9: out_o = 8'h56; 8'hba: out_o = 8'hf4; 8'hbb: out_o = 8'hea;
      8'hbc: out_o = 8'h65; 8'hbd: out_o = 8'h7a; 8'hbe: out_o = 8'hae; 8'hbf: out_o = 8'h08;
      8'hc0: out_o = 8'hba; 8'hc1: out_o = 8'h78; 8'hc2: out_o = 8'h25; 8'hc3: out_o = 8'h2e;
      8'hc4: out_o = 8'h1c; 8'hc5: out_o = 8'ha6; 8'hc6: out_o = 8'hb4; 8'hc7: out_o = 8'hc6;
      8'hc8: out_o = 8'he8; 8'hc9: out_o = 8'hdd; 8'hca: out_o = 8'h74; 8'hcb: out_o = 8'h1f;
      8'hcc: out_o = 8'h4b; 8'hcd: out_o = 8'hbd; 8'hce: out_o = 8'h8b; 8'hcf: out_o = 8'h8a;
      8'hd0: out_o = 8'h70; 8'hd1: out_o = 8'h3e; 8'hd2: out_o = 8'hb5; 8'hd3: out_o = 8'h66;
      8'hd4: out_o = 8'h48; 8'hd5: out_o = 8'h03; 8'hd6: out_o = 8'hf6; 8'hd7: out_o = 8'h0e;
      8'hd8: out_o = 8'h61; 8'hd9: out_o = 8'h35; 8'hda: out_o = 8'h57; 8'hdb: out_o = 8'hb9;
      8'hdc: out_o = 8'h86; 8'hdd: out_o = 8'hc1; 8'hde: out_o = 8'h1d; 8'hdf: out_o = 8'h9e;
      8'he0: out_o = 8'he1; 8'he1: out_o = 8'hf8; 8'he2: out_o = 8'h98; 8'he3: out_o = 8'h11;
      8'he4: out_o = 8'h69; 8'he5: out_o = 8'hd9; 8'he6: out_o = 8'h8e; 8'he7: out_o = 8'h94;
      8'he8: out_o = 8'h9b; 8'he9: out_o = 8'h1e; 8'hea: out_o = 8'h87; 8'heb: out_o = 8'he9;
      8'hec: out_o = 8'hce; 8'hed: out_o = 8'h55; 8'hee: out_o = 8'h28; 8'hef: out_o = 8'hdf;
      8'hf0: out_o = 8'h8c; 8'hf1: out_o = 8'ha1; 8'hf2: out_o = 8'h89; 8'hf3: out_o = 8'h0d;
      8'hf4: out_o = 8'hbf; 8'hf5: out_o = 8'he6; 8'hf6: out_o = 8'h42; 8'hf7: out_o = 8'h68;
      8'hf8: out_o = 8'h41; 8'hf9: out_o = 8'h99; 8'hfa: out_o = 8'h2d; 8'hfb: out_o = 8'h0f;
      8'hfc: out_o = 8'hb0; 8'hfd: out_o = 8'h54; 8'hfe: out_o = 8'hbb; 8'hff: out_o = 8'h16;
      default: out_o = 8'h00;
    endcase
  end

endmodule

module sub_shift_rows #(
  parameter int SBOX_COUNT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  localparam int ITER = 16 / SBOX_COUNT;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    inLatch_q, inLatch_d;
  logic [127:0]    outData_q, outData_d;
  logic            outValid_q, outValid_d;

  logic [3:0]      laneIdx  [SBOX_COUNT];
  logic [7:0]      laneByte [SBOX_COUNT];

  // ShiftRows is folded into the read side: output byte (r,c) reads input byte (r,c+r).
  for (genvar l = 0; l < SBOX_COUNT; l++) begin : gLane
    logic [3:0] outIdx;
    logic [3:0] srcIdx;
    assign outIdx     = 4'(int'(cnt_q) * SBOX_COUNT + l);
    assign srcIdx     = {outIdx[3:2] + outIdx[1:0], outIdx[1:0]};
    assign laneIdx[l] = outIdx;
    sub_shift_rows_sbox uSbox (
      .in_i  (inLatch_q[{~srcIdx, 3'b000} +: 8]),
      .out_o (laneByte[l])
    );
  end

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_valid = outValid_q;
  assign data_out  = outData_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inLatch_d  = inLatch_q;
    outData_d  = outData_q;
    outValid_d = outValid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          inLatch_d = data_in;
          cnt_d     = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        for (int l = 0; l < SBOX_COUNT; l++) begin
          outData_d[{~laneIdx[l], 3'b000} +: 8] = laneByte[l];
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) begin
          state_d    = DONE;
          outValid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          outValid_d = 1'b0;
          if (in_valid) begin
            inLatch_d = data_in;
            cnt_d     = '0;
            state_d   = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      inLatch_q  <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inLatch_q  <= inLatch_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
    end
  end

endmodule

// File: tb/tb_sub_shift_rows.sv
// Directed bench for sub_shift_rows: FIPS-197 vector, handshake corner cases,
// lane-count sweep and mid-block reset.

module tb_sub_shift_rows;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;

  logic         sInValid;
  logic [127:0] sDataIn;
  logic         sOutReady;
  logic         sInReady  [5];
  logic         sOutValid [5];
  logic [127:0] sDataOut  [5];

  int passCount;
  int totalCount;

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_MIX = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] ZERO_OUT = 128'h63636363636363636363636363636363;
  localparam logic [127:0] ONES_OUT = 128'h16161616161616161616161616161616;

  sub_shift_rows #(.SBOX_COUNT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  // Sweep instances with SBOX_COUNT = 1, 2, 4, 8, 16.
  for (genvar g = 0; g < 5; g++) begin : gSweep
    sub_shift_rows #(.SBOX_COUNT(1 << g)) uSweep (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sInValid),
      .in_ready  (sInReady[g]),
      .data_in   (sDataIn),
      .out_valid (sOutValid[g]),
      .out_ready (sOutReady),
      .data_out  (sDataOut[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(15-4*c) +: 8];
      a1 = s[8*(14-4*c) +: 8];
      a2 = s[8*(13-4*c) +: 8];
      a3 = s[8*(12-4*c) +: 8];
      r[8*(15-4*c) +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[8*(14-4*c) +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[8*(13-4*c) +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[8*(12-4*c) +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  // The input bus is scrambled right after the accept edge so a late sample would show.
  task automatic sendBlock(input logic [127:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in  = 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a;
  endtask

  task automatic waitOutValid(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!out_valid && edges < 40);
  endtask

  task automatic test_reset;
    #12;
    totalCount++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    else passCount++;
    totalCount++;
    if (data_out !== 128'h0) $display("[TB] FAIL reset_data_out: got %h expected 0", data_out);
    else passCount++;
    totalCount++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    else passCount++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fips_round1;
    int edges;
    sendBlock(FIPS_IN);
    totalCount++;
    if (in_ready !== 1'b0) $display("[TB] FAIL fips_busy_in_ready: got %b expected 0", in_ready);
    else passCount++;
    waitOutValid(edges);
    totalCount++;
    if (out_valid !== 1'b1 || edges !== 4)
      $display("[TB] FAIL fips_latency: got %0d edges (out_valid=%b) expected 4", edges, out_valid);
    else passCount++;
    totalCount++;
    if (data_out !== FIPS_OUT) $display("[TB] FAIL fips_data: got %h expected %h", data_out, FIPS_OUT);
    else passCount++;
  endtask

  task automatic test_mixcolumn_chain;
    logic [127:0] mixed;
    mixed = mixColumns(data_out);
    totalCount++;
    if (mixed !== FIPS_MIX) $display("[TB] FAIL mixcolumn_chain: got %h expected %h", mixed, FIPS_MIX);
    else passCount++;
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      totalCount++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_out !== FIPS_OUT)
        $display("[TB] FAIL backpressure_hold cycle %0d: got valid=%b ready=%b data=%h expected valid=1 ready=0 data=%h",
                 i, out_valid, in_ready, data_out, FIPS_OUT);
      else passCount++;
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    totalCount++;
    if (in_ready !== 1'b1) $display("[TB] FAIL done_ready_passthrough: got %b expected 1", in_ready);
    else passCount++;
    @(posedge clk);
    #1;
    totalCount++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("[TB] FAIL drain_to_idle: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    else passCount++;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int edges;
    sendBlock(128'h0);
    waitOutValid(edges);
    totalCount++;
    if (out_valid !== 1'b1 || data_out !== ZERO_OUT)
      $display("[TB] FAIL zero_data: got %h (valid=%b) expected %h", data_out, out_valid, ZERO_OUT);
    else passCount++;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = '1;
    #1;
    totalCount++;
    if (in_ready !== 1'b1) $display("[TB] FAIL b2b_in_ready: got %b expected 1", in_ready);
    else passCount++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in  = 128'h0;
    totalCount++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("[TB] FAIL b2b_accept: got valid=%b ready=%b expected valid=0 ready=0", out_valid, in_ready);
    else passCount++;
    waitOutValid(edges);
    totalCount++;
    if (out_valid !== 1'b1 || edges !== 4)
      $display("[TB] FAIL b2b_latency: got %0d edges (out_valid=%b) expected 4", edges, out_valid);
    else passCount++;
    totalCount++;
    if (data_out !== ONES_OUT) $display("[TB] FAIL b2b_data: got %h expected %h", data_out, ONES_OUT);
    else passCount++;
    @(posedge clk);
    #1;
    totalCount++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("[TB] FAIL b2b_to_idle: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    else passCount++;
    out_ready = 1'b0;
  endtask

  task automatic test_sbox_sweep;
    int expLat [5];
    int lat    [5];
    expLat = '{16, 8, 4, 2, 1};
    lat    = '{0, 0, 0, 0, 0};
    @(negedge clk);
    sInValid = 1'b1;
    sDataIn  = 128'h0;
    @(posedge clk);
    #1;
    sInValid = 1'b0;
    sDataIn  = 128'hffff0000ffff0000ffff0000ffff0000;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 5; g++) begin
        if (lat[g] == 0 && sOutValid[g] === 1'b1) lat[g] = e;
      end
    end
    for (int g = 0; g < 5; g++) begin
      totalCount++;
      if (lat[g] !== expLat[g])
        $display("[TB] FAIL sweep_latency lanes=%0d: got %0d expected %0d", 1 << g, lat[g], expLat[g]);
      else passCount++;
      totalCount++;
      if (sOutValid[g] !== 1'b1 || sInReady[g] !== 1'b0 || sDataOut[g] !== ZERO_OUT)
        $display("[TB] FAIL sweep_data lanes=%0d: got valid=%b ready=%b data=%h expected valid=1 ready=0 data=%h",
                 1 << g, sOutValid[g], sInReady[g], sDataOut[g], ZERO_OUT);
      else passCount++;
    end
    @(negedge clk);
    sOutReady = 1'b1;
    @(negedge clk);
    sOutReady = 1'b0;
  endtask

  task automatic test_reset_mid_block;
    sendBlock(FIPS_IN);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    totalCount++;
    if (out_valid !== 1'b0 || data_out !== 128'h0 || in_ready !== 1'b1)
      $display("[TB] FAIL midreset_immediate: got valid=%b ready=%b data=%h expected valid=0 ready=1 data=0",
               out_valid, in_ready, data_out);
    else passCount++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      totalCount++;
      if (out_valid !== 1'b0 || data_out !== 128'h0)
        $display("[TB] FAIL midreset_no_stale cycle %0d: got valid=%b data=%h expected valid=0 data=0",
                 i, out_valid, data_out);
      else passCount++;
    end
    totalCount++;
    if (in_ready !== 1'b1) $display("[TB] FAIL midreset_idle_ready: got %b expected 1", in_ready);
    else passCount++;
  endtask

  initial begin
    passCount  = 0;
    totalCount = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    data_in    = 128'h0;
    out_ready  = 1'b0;
    sInValid   = 1'b0;
    sDataIn    = 128'h0;
    sOutReady  = 1'b0;
    test_reset;
    test_fips_round1;
    test_mixcolumn_chain;
    test_backpressure;
    test_back_to_back;
    test_sbox_sweep;
    test_reset_mid_block;
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
